// File: rtl/ex_mem_if.sv
// Execute-to-memory bus: upstream entry from the ALU side plus the buffered entry
// presented to the data-memory stage.
// Handshake: an entry moves when valid & ready are both high at a rising edge;
// a producer holding valid keeps its payload stable until that edge, and ready
// never depends combinationally on the same side's valid.
interface ex_mem_if #(
    parameter int DW = 64,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_alu_y;
    logic          in_z;
    logic [DW-1:0] in_store_data;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_br_off;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          in_reg_write;
    logic          in_mem_to_reg;
    logic          in_branch;
    logic          in_cbz;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_alu_y;
    logic [DW-1:0] out_store_data;
    logic [RW-1:0] out_rd;
    logic          out_mem_read;
    logic          out_mem_write;
    logic          out_reg_write;
    logic          out_mem_to_reg;

    modport slave (
        input  in_valid, in_alu_y, in_z, in_store_data, in_rd, in_pc, in_br_off,
        input  in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch, in_cbz,
        input  out_ready,
        output in_ready,
        output out_valid, out_alu_y, out_store_data, out_rd,
        output out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg
    );

    modport master (
        output in_valid, in_alu_y, in_z, in_store_data, in_rd, in_pc, in_br_off,
        output in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch, in_cbz,
        output out_ready,
        input  in_ready,
        input  out_valid, out_alu_y, out_store_data, out_rd,
        input  out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer toward data memory plus B/CBZ
// resolution producing a one-cycle PC redirect to fetch.
module ex_mem_stage #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    ex_mem_if.slave       bus,
    output logic          redirect_valid,
    output logic [DW-1:0] redirect_pc,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DW-1:0] alu_y;
        logic [DW-1:0] store_data;
        logic [RW-1:0] rd;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic          mem_to_reg;
    } entry_t;

    state_e        state_q, state_d;
    entry_t        main_q, main_d;
    entry_t        skid_q, skid_d;
    logic          redir_valid_q, redir_valid_d;
    logic [DW-1:0] redir_pc_q, redir_pc_d;

    entry_t        in_entry;
    logic          accept;
    logic          fire;
    logic          enq;
    logic          taken;

    always_comb begin
        in_entry            = '0;
        in_entry.alu_y      = bus.in_alu_y;
        in_entry.store_data = bus.in_store_data;
        in_entry.rd         = bus.in_rd;
        in_entry.mem_read   = bus.in_mem_read;
        in_entry.mem_write  = bus.in_mem_write;
        in_entry.reg_write  = bus.in_reg_write;
        in_entry.mem_to_reg = bus.in_mem_to_reg;
    end

    assign bus.in_ready  = (state_q != S_TWO) & rst_n;
    assign bus.out_valid = (state_q != S_EMPTY);

    assign accept = bus.in_valid & bus.in_ready & ~flush;
    assign fire   = bus.out_valid & bus.out_ready;
    // Branches and NOPs carry no memory or writeback work, so they never occupy a slot.
    assign enq    = accept & (bus.in_mem_read | bus.in_mem_write | bus.in_reg_write);
    assign taken  = accept & (bus.in_branch | (bus.in_cbz & bus.in_z));

    always_comb begin
        state_d       = state_q;
        main_d        = main_q;
        skid_d        = skid_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (enq) begin
                        state_d = S_ONE;
                        main_d  = in_entry;
                    end
                end
                S_ONE: begin
                    if (enq && fire) begin
                        main_d = in_entry;
                    end else if (enq) begin
                        state_d = S_TWO;
                        skid_d  = in_entry;
                    end else if (fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (fire) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
            if (taken) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = bus.in_pc + (bus.in_br_off << 2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign bus.out_alu_y      = main_q.alu_y;
    assign bus.out_store_data = main_q.store_data;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_mem_read   = main_q.mem_read;
    assign bus.out_mem_write  = main_q.mem_write;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.out_mem_to_reg = main_q.mem_to_reg;

    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, checked each
// cycle against a queue-based model of the stage.
module tb_ex_mem_stage;

    localparam int DW = 64;
    localparam int RW = 5;
    localparam int EW = 2 * DW + RW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    logic          m_rv;
    logic [DW-1:0] m_rpc;
    bit            m_known;
    bit            m_out_zero;

    ex_mem_if #(.DW(DW), .RW(RW)) bus ();

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [DW-1:0] y, input logic [DW-1:0] sd,
                                           input logic [RW-1:0] rd, input logic mr, input logic mw,
                                           input logic rw, input logic m2r);
        return {y, sd, rd, mr, mw, rw, m2r};
    endfunction

    function automatic logic [EW-1:0] dut_vec();
        return pack(bus.out_alu_y, bus.out_store_data, bus.out_rd, bus.out_mem_read,
                    bus.out_mem_write, bus.out_reg_write, bus.out_mem_to_reg);
    endfunction

    // Model update at a rising edge, from the inputs held during the cycle.
    task automatic model_edge();
        bit acc;
        bit fire;
        bit useful;
        if (!rst_n) begin
            exp_q.delete();
            m_rv       = 1'b0;
            m_rpc      = '0;
            m_known    = 1'b1;
            m_out_zero = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            m_rv = 1'b0;
        end else begin
            acc    = bus.in_valid && (exp_q.size() < 2);
            fire   = (exp_q.size() > 0) && bus.out_ready;
            useful = bus.in_mem_read || bus.in_mem_write || bus.in_reg_write;
            if (fire) void'(exp_q.pop_front());
            if (acc && useful) begin
                exp_q.push_back(pack(bus.in_alu_y, bus.in_store_data, bus.in_rd, bus.in_mem_read,
                                     bus.in_mem_write, bus.in_reg_write, bus.in_mem_to_reg));
                m_out_zero = 1'b0;
            end
            m_rv = acc && (bus.in_branch || (bus.in_cbz && bus.in_z));
            if (m_rv) m_rpc = bus.in_pc + bus.in_br_off * 64'd4;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        check("in_ready", bus.in_ready, (rst_n && exp_q.size() < 2));
        if (m_known) begin
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("out_bus", dut_vec(), exp_q[0]);
            else if (m_out_zero) check("out_zero", dut_vec(), '0);
            check("redir_valid", redirect_valid, m_rv);
            check("redir_pc", redirect_pc, m_rpc);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_alu_y       = '0;
        bus.in_z           = 1'b0;
        bus.in_store_data  = '0;
        bus.in_rd          = '0;
        bus.in_pc          = '0;
        bus.in_br_off      = '0;
        bus.in_mem_read    = 1'b0;
        bus.in_mem_write   = 1'b0;
        bus.in_reg_write   = 1'b0;
        bus.in_mem_to_reg  = 1'b0;
        bus.in_branch      = 1'b0;
        bus.in_cbz         = 1'b0;
    endtask

    task automatic send_alu(input logic [DW-1:0] y);
        idle();
        bus.in_valid     = 1'b1;
        bus.in_alu_y     = y;
        bus.in_reg_write = 1'b1;
        bus.in_rd        = RW'(y[4:0]);
    endtask

    task automatic send_br(input logic b, input logic cbz, input logic z,
                           input logic [DW-1:0] pc, input logic [DW-1:0] off);
        idle();
        bus.in_valid  = 1'b1;
        bus.in_branch = b;
        bus.in_cbz    = cbz;
        bus.in_z      = z;
        bus.in_pc     = pc;
        bus.in_br_off = off;
    endtask

    initial begin
        m_known       = 1'b0;
        m_out_zero    = 1'b0;
        m_rv          = 1'b0;
        m_rpc         = '0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        @(negedge clk);

        // Reset held for two cycles, then released.
        tick();
        tick();
        check("rst_in_ready_low", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_redir_valid", redirect_valid, 1'b0);
        check("rst_out_zero", dut_vec(), '0);
        check("rst_in_ready_high", bus.in_ready, 1'b1);
        tick();

        // Back-to-back stream with the memory stage always ready.
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send_alu(64'(i * 16));
            tick();
            check("stream_y", bus.out_alu_y, 64'(i * 16));
            check("stream_ready", bus.in_ready, 1'b1);
        end
        idle();
        tick();

        // Stall fills both slots, then drains in order.
        bus.out_ready = 1'b0;
        send_alu(64'hA);
        tick();
        send_alu(64'hB);
        tick();
        idle();
        check("stall_ready", bus.in_ready, 1'b0);
        check("stall_state", dbg_state, 2'd2);
        check("stall_hold_y", bus.out_alu_y, 64'hA);
        tick();
        check("stall_still_a", bus.out_alu_y, 64'hA);
        bus.out_ready = 1'b1;
        tick();
        check("drain_b", bus.out_alu_y, 64'hB);
        check("drain_ready", bus.in_ready, 1'b1);
        tick();
        check("drain_empty", bus.out_valid, 1'b0);

        // CBZ taken with a negative offset, then not taken.
        send_br(1'b0, 1'b1, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        idle();
        check("cbz_pulse", redirect_valid, 1'b1);
        check("cbz_pc", redirect_pc, 64'hF8);
        check("cbz_not_enq", bus.out_valid, 1'b0);
        tick();
        check("cbz_one_cycle", redirect_valid, 1'b0);
        check("cbz_pc_hold", redirect_pc, 64'hF8);
        send_br(1'b0, 1'b1, 1'b0, 64'h200, 64'h4);
        tick();
        idle();
        check("cbz_nt", redirect_valid, 1'b0);
        tick();

        // Unconditional B whose target wraps past 2^64.
        send_br(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8);
        tick();
        idle();
        check("b_wrap_pulse", redirect_valid, 1'b1);
        check("b_wrap_pc", redirect_pc, 64'h10);
        tick();

        // Flush while full, racing an accepted taken branch.
        bus.out_ready = 1'b0;
        send_alu(64'h1);
        tick();
        send_alu(64'h2);
        tick();
        send_br(1'b1, 1'b0, 1'b0, 64'h40, 64'h1);
        bus.in_reg_write = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        check("flush_empty", bus.out_valid, 1'b0);
        check("flush_no_redir", redirect_valid, 1'b0);
        check("flush_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        send_alu(64'h55);
        tick();
        idle();
        check("post_flush_valid", bus.out_valid, 1'b1);
        check("post_flush_y", bus.out_alu_y, 64'h55);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n              = ($urandom_range(0, 59) != 0);
            flush              = ($urandom_range(0, 19) == 0);
            bus.out_ready      = ($urandom_range(0, 2) != 0);
            bus.in_valid       = ($urandom_range(0, 3) != 0);
            bus.in_alu_y       = {$urandom, $urandom};
            bus.in_store_data  = {$urandom, $urandom};
            bus.in_rd          = RW'($urandom_range(0, 31));
            bus.in_pc          = {$urandom, $urandom};
            bus.in_br_off      = {$urandom, $urandom};
            bus.in_z           = $urandom_range(0, 1) != 0;
            bus.in_mem_read    = $urandom_range(0, 3) == 0;
            bus.in_mem_write   = $urandom_range(0, 3) == 0;
            bus.in_reg_write   = $urandom_range(0, 1) != 0;
            bus.in_mem_to_reg  = $urandom_range(0, 1) != 0;
            bus.in_branch      = $urandom_range(0, 5) == 0;
            bus.in_cbz         = $urandom_range(0, 4) == 0;
            tick();
        end

        rst_n = 1'b1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
